// File: rtl/data_sram_responder.sv
// -----------------------------------------------------------------------------
// data_sram_responder
//
// Memory-side responder for the CPU's SRAM-style data port. It holds a
// word-addressed RAM of 2^ADDR_W 32-bit words. Reads return data one cycle
// after the access edge. Writes use per-byte enables. The RAM is read-first:
// a write also returns the word's previous contents. Addresses outside the
// decoded window return 32'hDEAD_BEEF and raise a one-cycle addr_err pulse.
//
// Optional feature (macro SRAM_WAIT_STATE_EN):
//   When the macro is defined, each request is stretched by WAIT_CYCLES stall
//   cycles. This exercises the core's memory-stall path. When the macro is
//   undefined, or when WAIT_CYCLES = 0, sram_stall stays low and every access
//   completes in a single cycle.
//
// Parameters:
//   ADDR_W      word-index width (RAM depth = 2^ADDR_W words)
//   BASE_ADDR   byte base of the window; only bits [31:ADDR_W+2] are decoded
//   WAIT_CYCLES stall cycles per access (0..15), used with SRAM_WAIT_STATE_EN
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   sram_en     request valid this cycle
//   sram_wen    byte write enables (bit i -> wdata[8i+7:8i]); 0 means read
//   sram_addr   byte address; bits [1:0] are ignored
//   sram_wdata  write data
//   sram_rdata  registered read data (valid one cycle after the access edge)
//   sram_stall  requester must hold en/wen/addr/wdata stable while high
//   addr_err    one-cycle pulse, aligned with rdata, for an out-of-window access
// -----------------------------------------------------------------------------
module data_sram_responder #(
  parameter int          ADDR_W      = 12,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_en,
  input  logic [3:0]  sram_wen,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  output logic        sram_stall,
  output logic        addr_err
);

  localparam int          DEPTH    = 1 << ADDR_W;
  localparam logic [31:0] MISS_VAL = 32'hDEAD_BEEF;

  logic [31:0]       mem [0:DEPTH-1];
  logic [ADDR_W-1:0] idx;
  logic              hit;
  logic              is_write;
  logic              do_access;
  logic              unused_addr_bits;

  // Byte-lane bits of the address never select anything in a word RAM.
  assign unused_addr_bits = ^sram_addr[1:0];

  // The window decode compares only the bits above the RAM index. Indices
  // therefore wrap naturally inside the window.
  assign idx      = sram_addr[ADDR_W+1:2];
  assign hit      = (sram_addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign is_write = (sram_wen != 4'b0000);

`ifdef SRAM_WAIT_STATE_EN
  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic       USE_WAIT  = (WAIT_CYCLES != 0);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t     state;
  logic [3:0] cnt;

  // A request raises stall in the same cycle it appears. This is why stall
  // must be combinational. Stall stays high until the countdown in WAIT
  // reaches zero. Stall is masked by reset, so it drops immediately when
  // reset is asserted, even while a request is still presented.
  always_comb begin
    sram_stall = 1'b0;
    do_access  = sram_en;
    if (USE_WAIT) begin
      sram_stall = ~reset & (((state == IDLE) & sram_en) |
                             ((state == WAIT) & (cnt != 4'd0)));
      // In WAIT the access completes on the final edge with whatever inputs
      // are present. It completes even if sram_en was dropped illegally.
      do_access  = (state == WAIT) & (cnt == 4'd0);
    end
  end

  // Wait-state sequencer: IDLE -> WAIT (load WAIT_CYCLES-1) -> count down ->
  // IDLE on the edge that performs the access. If reset arrives mid-wait, no
  // access edge is ever reached, so a pending write is simply dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (USE_WAIT && sram_en) begin
            state <= WAIT;
            cnt   <= WAIT_INIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end
`else
  assign sram_stall = 1'b0;
  assign do_access  = sram_en;
`endif

  // RAM write port. Only enabled bytes of an in-window word are updated.
  // The RAM has no reset, so its contents survive a reset.
  always_ff @(posedge clk) begin
    if (do_access && is_write && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_wen[b]) begin
          mem[idx][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response register. It samples the pre-write word (read-first) on every
  // access, writes included. A miss returns the marker value with addr_err.
  // Idle cycles hold rdata and clear addr_err, so the error shows as a pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sram_rdata <= 32'h0000_0000;
      addr_err   <= 1'b0;
    end else if (do_access) begin
      if (hit) begin
        sram_rdata <= mem[idx];
        addr_err   <= 1'b0;
      end else begin
        sram_rdata <= MISS_VAL;
        addr_err   <= 1'b1;
      end
    end else begin
      addr_err <= 1'b0;
    end
  end

endmodule
